timer_core: RTL and testbench
=============================

Name: timer_core

Overview:
- Programmable down-count timer in the timer subsystem, directly downstream of the clock generator/divider stage.
- Consumes the generated clock as `clk`.
- A prescaler divides `clk` into ticks; a down-counter decrements on each tick and flags compare-match and expiry events.
- Supports one-shot and periodic modes, with a sticky interrupt flag cleared by software.

Parameters:
- CNT_W, 16, width of main counter, load_val, cmp_val
- PRE_W, 12, width of prescaler (matches divider output width)

Ports:
- clk  input  1  timer clock (from clock generator)
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  level; 0 freezes prescaler and counter
- start  input  1  pulse; load counter and begin counting
- stop  input  1  pulse; halt and return to IDLE, count held
- mode  input  1  0 = one-shot, 1 = periodic
- load_val  input  CNT_W  counter start/reload value
- prescale  input  PRE_W  tick every prescale+1 enabled cycles
- cmp_val  input  CNT_W  compare value
- irq_clr  input  1  pulse; clears irq
- count  output  CNT_W  current counter value
- tick  output  1  one-cycle prescaled tick pulse
- cmp_match  output  1  one-cycle pulse, counter reached cmp_val
- expired  output  1  one-cycle pulse, counter passed 0
- irq  output  1  sticky, set by expiry
- busy  output  1  1 while in RUN

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE.
  - count, internal pre_cnt, tick, cmp_match, expired, irq, busy all 0.
- Scope:
  - Single clock domain; all outputs registered.
  - Only tick, cmp_match and expired are pulses.
- States:
  - IDLE: busy=0; counter and prescaler held.
  - RUN: busy=1.
- IDLE -> RUN:
  - Trigger: start=1 with stop=0.
  - Next edge: count<=load_val, pre_cnt<=0, busy<=1.
- RUN, enable=1:
  - pre_cnt increments each cycle.
  - When pre_cnt==prescale: pre_cnt<=0, tick<=1 for one cycle.
  - On that tick edge, if count!=0: count<=count-1.
  - On that tick edge, if count==0: expired<=1 for one cycle.
    - mode=1: count<=load_val, stay RUN.
    - mode=0: count stays 0, RUN -> IDLE, busy<=0.
- RUN, enable=0:
  - pre_cnt and count frozen; no tick, cmp_match or expired.
  - start and stop still act.
- Timing:
  - First tick occurs prescale+1 enabled cycles after entering RUN.
  - Expiry period = (load_val+1)*(prescale+1) enabled cycles.
  - prescale=0 gives a tick every enabled cycle.
- Mode sampling: mode is sampled at the expiry tick only.
- cmp_match:
  - Pulses on a tick edge where the new count value equals cmp_val.
  - New count value means the decremented value or the reloaded value.
  - It never fires on the start load itself.
  - If cmp_val==0, cmp_match and the decrement-to-0 coincide; expired fires one tick later.
- load_val=0: expired fires on every tick in periodic mode; cmp_match never fires unless cmp_val==0 on reload.
- start while RUN: restart; count<=load_val, pre_cnt<=0, no event pulses that cycle.
- stop while RUN: next edge state=IDLE, busy=0, count holds its value, pre_cnt<=0, no pulses.
- start and stop in the same cycle: stop wins.
- irq:
  - Set on any expired pulse; irq_clr=1 clears it.
  - Simultaneous set and clear: set wins (irq stays 1).
  - irq is unaffected by stop and start.
- Wrap-around: counter never underflows below 0; prescaler wraps at prescale.
- prescale change mid-run: takes effect on the next compare.
  - If pre_cnt already > the new prescale, the prescaler counts up and wraps at 2^PRE_W before ticking; software avoids this.
- Reset mid-operation: immediate return to reset values, including irq=0.

Test Plan:
- One-shot: load_val=3, prescale=1, mode=0, start pulse, enable=1 -> tick every 2 cycles; count 3,2,1,0; expired pulse 8 cycles after entering RUN; busy falls same edge; irq=1 and stays 1.
- Periodic with compare: load_val=4, prescale=0, cmp_val=2, mode=1 -> expired every 5 cycles, count reloads to 4; cmp_match pulses each time count becomes 2; runs 3 periods.
- Pause and stop: mid-run at count=5, drop enable 10 cycles -> count stays 5, no tick; re-enable resumes; stop at count=3 -> busy=0, count=3 held, no expired.
- Collisions: start+stop same cycle in RUN -> IDLE; expired coinciding with irq_clr -> irq remains 1; irq_clr alone on the next cycle -> irq=0.
- Edge values: load_val=0, prescale=0, periodic -> expired every cycle; prescale=4095, load_val=0 -> first expired after 4096 cycles.
- Async reset: assert rst_n=0 mid-count, between clock edges -> all outputs 0 immediately; after release, IDLE until start.

Source files
------------

// File: rtl/timer_core.sv
// Programmable prescaled down-count timer: one-shot/periodic modes, compare-match
// and expiry pulses, sticky software-cleared interrupt.
module timer_core #(
  parameter int CNT_W = 16,
  parameter int PRE_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [CNT_W-1:0] load_val,
  input  logic [PRE_W-1:0] prescale,
  input  logic [CNT_W-1:0] cmp_val,
  input  logic             irq_clr,
  output logic [CNT_W-1:0] count,
  output logic             tick,
  output logic             cmp_match,
  output logic             expired,
  output logic             irq,
  output logic             busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [PRE_W-1:0] pre_cnt, pre_n;
  logic [CNT_W-1:0] count_n, dec;
  logic             tick_n, cmp_n, exp_n, irq_n;

  always_comb begin
    state_n = state;
    count_n = count;
    pre_n   = pre_cnt;
    tick_n  = 1'b0;
    cmp_n   = 1'b0;
    exp_n   = 1'b0;
    dec     = count - 1'b1;
    // stop beats start; both are honoured regardless of enable
    if (stop && state == RUN) begin
      state_n = IDLE;
      pre_n   = '0;
    end else if (start && !stop) begin
      state_n = RUN;
      count_n = load_val;
      pre_n   = '0;
    end else if (state == RUN && enable) begin
      if (pre_cnt == prescale) begin
        pre_n  = '0;
        tick_n = 1'b1;
        if (count != '0) begin
          count_n = dec;
          cmp_n   = (dec == cmp_val);
        end else begin
          exp_n = 1'b1;
          if (mode) begin
            count_n = load_val;
            cmp_n   = (load_val == cmp_val);
          end else begin
            state_n = IDLE;
          end
        end
      end else begin
        pre_n = pre_cnt + 1'b1;
      end
    end
    // a new expiry outranks a simultaneous clear
    irq_n = exp_n | (irq & ~irq_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      pre_cnt   <= '0;
      tick      <= 1'b0;
      cmp_match <= 1'b0;
      expired   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      pre_cnt   <= pre_n;
      tick      <= tick_n;
      cmp_match <= cmp_n;
      expired   <= exp_n;
      irq       <= irq_n;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_timer_core.sv
// Scoreboard bench for timer_core: stimulus queues expected cmp_match/expired
// events (cycle + count), a negedge monitor pops and compares them.
module tb_timer_core;
  localparam int CNT_W = 16;
  localparam int PRE_W = 12;
  localparam int K_CMP = 0;
  localparam int K_EXP = 1;

  logic             clk, rst_n, enable, start, stop, mode, irq_clr;
  logic [CNT_W-1:0] load_val, cmp_val, count;
  logic [PRE_W-1:0] prescale;
  logic             tick, cmp_match, expired, irq, busy;

  typedef struct {int kind; int cyc; int cnt;} ev_t;
  ev_t exp_q[$];

  int cyc = 0;
  int tick_cnt = 0;
  int cmpd = 0;
  int errs = 0;

  timer_core #(.CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .stop(stop),
    .mode(mode), .load_val(load_val), .prescale(prescale), .cmp_val(cmp_val),
    .irq_clr(irq_clr), .count(count), .tick(tick), .cmp_match(cmp_match),
    .expired(expired), .irq(irq), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    cmpd++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push_ev(input int k, input int c, input int n);
    ev_t e;
    e.kind = k; e.cyc = c; e.cnt = n;
    exp_q.push_back(e);
  endfunction

  task automatic sb_pop(input int k);
    ev_t e;
    cmpd++;
    if (exp_q.size() == 0) begin
      errs++;
      $display("FAIL unexpected_%s: pulse at cyc %0d count %0d, none expected",
               (k == K_CMP) ? "cmp_match" : "expired", cyc, count);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.cnt != int'(count)) begin
        errs++;
        $display("FAIL event: got kind %0d cyc %0d count %0d expected kind %0d cyc %0d count %0d",
                 k, cyc, count, e.kind, e.cyc, e.cnt);
      end
    end
  endtask

  // monitor: pulses are sampled mid-cycle; cmp_match checked before expired
  always @(negedge clk) begin
    if (rst_n) begin
      if (tick) tick_cnt++;
      if (cmp_match) sb_pop(K_CMP);
      if (expired) sb_pop(K_EXP);
    end
  end

  task automatic start_pulse();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    int c, snap;
    rst_n = 1'b0; enable = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
    irq_clr = 1'b0; load_val = '0; cmp_val = 16'hFFFF; prescale = '0;
    step(2);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_irq", irq, 0);
    chk("rst_pulses", {tick, cmp_match, expired}, 0);
    rst_n = 1'b1;
    step(2);
    chk("idle_busy", busy, 0);

    // one-shot: ticks every 2 cycles, cmp at count 2, expiry 8 cycles into RUN
    load_val = 3; prescale = 1; mode = 1'b0; cmp_val = 2;
    c = cyc;
    push_ev(K_CMP, c + 3, 2);
    push_ev(K_EXP, c + 9, 0);
    start_pulse();
    chk("os_load_count", count, 3);
    chk("os_busy", busy, 1);
    step(7);
    chk("os_busy_before_exp", busy, 1);
    step(1);
    chk("os_busy_fall", busy, 0);
    chk("os_irq_set", irq, 1);
    step(4);
    chk("os_irq_sticky", irq, 1);
    chk("os_count_hold", count, 0);

    // periodic with compare, three periods then stop
    load_val = 4; prescale = 0; mode = 1'b1; cmp_val = 2;
    c = cyc;
    for (int p = 0; p < 3; p++) begin
      push_ev(K_CMP, c + 3 + 5 * p, 2);
      push_ev(K_EXP, c + 6 + 5 * p, 4);
    end
    start_pulse();
    step(15);
    chk("per_count_reload", count, 4);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("per_stop_busy", busy, 0);
    chk("per_stop_count", count, 4);

    // pause with enable low, resume, stop at count 3
    load_val = 8; prescale = 0; mode = 1'b0; cmp_val = 16'hFFFF;
    start_pulse();
    step(3);
    chk("pause_pre_count", count, 5);
    enable = 1'b0;
    step(1);
    snap = tick_cnt;
    step(9);
    chk("pause_count", count, 5);
    chk("pause_ticks", tick_cnt - snap, 0);
    enable = 1'b1;
    step(2);
    chk("resume_count", count, 3);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    step(3);
    chk("stop_count_held", count, 3);

    // start+stop together while running: stop wins
    load_val = 5; mode = 1'b1;
    start_pulse();
    step(2);
    start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", busy, 0);
    chk("startstop_count", count, 3);

    // irq clear, then clear colliding with an expiry
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    chk("irq_clr", irq, 0);
    load_val = 0; mode = 1'b0;
    c = cyc;
    push_ev(K_EXP, c + 2, 0);
    start_pulse();
    irq_clr = 1'b1;
    step(1);
    chk("irq_set_wins", irq, 1);
    step(1);
    irq_clr = 1'b0;
    chk("irq_clr_after", irq, 0);

    // cmp_val 0: match on decrement to 0, expiry one tick later
    load_val = 2; cmp_val = 0;
    c = cyc;
    push_ev(K_CMP, c + 3, 0);
    push_ev(K_EXP, c + 4, 0);
    start_pulse();
    step(5);
    cmp_val = 16'hFFFF;

    // load 0, prescale 0, periodic: expiry every cycle
    load_val = 0; mode = 1'b1;
    c = cyc;
    for (int i = 2; i <= 4; i++) push_ev(K_EXP, c + i, 0);
    start_pulse();
    step(3);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("ev_every_busy", busy, 0);

    // max prescale: first expiry 4096 cycles into RUN
    prescale = 12'hFFF; mode = 1'b0;
    c = cyc;
    push_ev(K_EXP, c + 4097, 0);
    start_pulse();
    step(4095);
    chk("maxpre_busy", busy, 1);
    step(1);
    chk("maxpre_done", busy, 0);
    step(2);

    // async reset between edges
    prescale = 0; load_val = 100;
    start_pulse();
    step(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_irq", irq, 0);
    step(2);
    #2;
    rst_n = 1'b1;
    step(3);
    chk("post_rst_idle", busy, 0);
    chk("post_rst_count", count, 0);
    load_val = 7;
    start_pulse();
    chk("post_rst_start", count, 7);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(2);

    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      cmpd++;
      errs++;
      $display("FAIL missing_event: got none expected kind %0d at cyc %0d count %0d",
               e.kind, e.cyc, e.cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpd, errs);
    $finish;
  end
endmodule
